// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryptor.
package aes_pkg;

    localparam int NROUNDS = 10;
    localparam int KEYW    = (NROUNDS + 1) * 128;

    typedef logic [127:0]     block_t;
    typedef logic [KEYW-1:0]  ekey_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    // Round r key sits at the top of the schedule for r=0 and walks down 128 bits per round.
    function automatic block_t roundkey(ekey_t k, int r);
        return k[KEYW-1-128*r -: 128];
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, which also maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes and ShiftRows together; byte i is row i%4, column i/4, MSB first.
    function automatic block_t sub_shift(block_t b);
        block_t o;
        int     src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127-8*i -: 8] = sbox(b[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic block_t mix_columns(block_t b);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[127-32*c -: 8];
            a1 = b[119-32*c -: 8];
            a2 = b[111-32*c -: 8];
            a3 = b[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES round datapath: full round (1..9) or final round (10, no MixColumns).

module encryptionRound
    import aes_pkg::*;
(
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = mix_columns(sub_shift(data)) ^ key;
endmodule

module round10
    import aes_pkg::*;
(
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = sub_shift(data) ^ key;
endmodule

module aes_round_unit (
    input  logic [127:0] data,
    input  logic [127:0] key,
    input  logic         final_rnd,
    output logic [127:0] result
);
    logic [127:0] full_res;
    logic [127:0] last_res;

    encryptionRound u_full (.data(data), .key(key), .result(full_res));
    round10         u_last (.data(data), .key(key), .result(last_res));

    assign result = final_rnd ? last_res : full_res;
endmodule

// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encryption sequencer: one shared round unit stepped through rounds 1..10.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// ROUND | applying round round_idx to state_reg, busy=1
// DONE  | ciphertext presented, in_ready follows out_ready
module aes_enc_sequencer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    input  logic [KEYW-1:0]   key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      cipher_out,
    output logic              busy,
    output logic [3:0]        round_idx,
    input  logic              clear
);
    seq_state_t fsm, fsm_nxt;
    block_t     state_reg, state_nxt, cipher_nxt, rnd_result, rnd_key;
    ekey_t      key_reg, key_nxt;
    logic [3:0] round_nxt;
    logic       out_valid_nxt;
    logic       final_rnd;
    logic       load;

    assign final_rnd = (round_idx == 4'(NROUNDS));
    assign rnd_key   = roundkey(key_reg, int'(round_idx));

    aes_round_unit u_round (
        .data      (state_reg),
        .key       (rnd_key),
        .final_rnd (final_rnd),
        .result    (rnd_result)
    );

    // State, datapath and output registers; all cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            state_reg  <= '0;
            key_reg    <= '0;
            round_idx  <= '0;
            cipher_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            state_reg  <= state_nxt;
            key_reg    <= key_nxt;
            round_idx  <= round_nxt;
            cipher_out <= cipher_nxt;
            out_valid  <= out_valid_nxt;
        end
    end

    // Next-state and handshake decode; clear overrides both accept and round completion.
    always_comb begin
        fsm_nxt       = fsm;
        state_nxt     = state_reg;
        key_nxt       = key_reg;
        round_nxt     = round_idx;
        cipher_nxt    = cipher_out;
        out_valid_nxt = out_valid;
        in_ready      = 1'b0;
        busy          = 1'b0;
        load          = 1'b0;

        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            ROUND: begin
                busy      = 1'b1;
                state_nxt = rnd_result;
                if (final_rnd) begin
                    cipher_nxt    = rnd_result;
                    out_valid_nxt = 1'b1;
                    round_nxt     = '0;
                    fsm_nxt       = DONE;
                end else begin
                    round_nxt = round_idx + 4'd1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    fsm_nxt       = IDLE;
                    load          = in_valid;
                end
            end
            default: fsm_nxt = IDLE;
        endcase

        if (load) begin
            key_nxt   = key_in;
            state_nxt = data_in ^ key_in[KEYW-1 -: 128];
            round_nxt = 4'd1;
            fsm_nxt   = ROUND;
        end

        if (clear) begin
            fsm_nxt       = IDLE;
            out_valid_nxt = 1'b0;
            round_nxt     = '0;
            cipher_nxt    = cipher_out;
            state_nxt     = state_reg;
            key_nxt       = key_reg;
        end
    end

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Self-checking bench for aes_enc_sequencer with a byte-array AES-128 reference model.
module tb_aes_enc_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  data_in;
    logic [1407:0] key_in;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  cipher_out;
    logic          busy;
    logic [3:0]    round_idx;
    logic          clear;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] sb[256];

    aes_enc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .key_in     (key_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cipher_out (cipher_out),
        .busy       (busy),
        .round_idx  (round_idx),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(logic [127:0] key);
        logic [31:0]   w[44];
        logic [31:0]   tmp;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ek;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) ek[1407-32*i -: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] encrypt(logic [1407:0] ek, logic [127:0] pt);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a[4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[1407-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = mul(a[r], 8'h02) ^ mul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[1407-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1407:0] rand_key();
        logic [1407:0] k;
        for (int i = 0; i < 44; i++) k[1407-32*i -: 32] = $urandom;
        return k;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Accept one block, scramble inputs while it is in flight, then check result and timing.
    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp);
        int lat;
        int nbusy;
        data_in   = pt;
        key_in    = expand(key);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat   = 1;
        nbusy = busy ? 1 : 0;
        while (!out_valid && lat < 30) begin
            data_in  = rand128();
            key_in   = rand_key();
            in_valid = 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (busy) nbusy++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, 128'(lat), 128'd11);
        chk({name, "_busy_cycles"}, 128'(nbusy), 128'd10);
        chk({name, "_cipher"}, cipher_out, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_valid_after_handoff"}, 128'(out_valid), 128'd0);
        chk({name, "_ready_after_handoff"}, 128'(in_ready), 128'd1);
    endtask

    task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
        data_in  = pt;
        key_in   = expand(key);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        int seen;
        int last;
        int waited;
        logic bad;
        logic [127:0] held;
        logic [127:0] rk;
        logic [127:0] rp;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        data_in = '0; key_in = '0;
        build_sbox();

        vecs[0] = '{pt: PT_B, key: KEY_B, ct: CT_B};
        vecs[1] = '{pt: PT_C, key: KEY_C, ct: CT_C};
        for (int i = 2; i < 8; i++) begin
            rk = rand128();
            rp = rand128();
            vecs[i] = '{pt: rp, key: rk, ct: encrypt(expand(rk), rp)};
        end

        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        chk("rst_cipher", cipher_out, 128'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            run_block($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key, vecs[i].ct);

        // back-to-back with in_valid and out_ready held high
        data_in = PT_C; key_in = expand(KEY_C); in_valid = 1'b1; out_ready = 1'b1;
        n = 0; seen = 0; last = 0;
        while (seen < 3 && n < 60) begin
            tick();
            n++;
            if (out_valid) begin
                seen++;
                chk($sformatf("b2b_cipher%0d", seen), cipher_out, CT_C);
                chk($sformatf("b2b_interval%0d", seen), 128'(n - last), 128'd11);
                last = n;
                if (seen == 3) in_valid = 1'b0;
            end
        end
        chk("b2b_count", 128'(seen), 128'd3);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_ready", 128'(in_ready), 128'd1);
        chk("b2b_idle_valid", 128'(out_valid), 128'd0);

        // backpressure
        start_block(PT_B, KEY_B);
        waited = 0;
        while (!out_valid && waited < 30) begin tick(); waited++; end
        chk("bp_valid", 128'(out_valid), 128'd1);
        chk("bp_cipher", cipher_out, CT_B);
        held = cipher_out;
        bad = 1'b0;
        repeat (20) begin
            in_valid = 1'b1;
            data_in  = rand128();
            tick();
            if (!out_valid || cipher_out !== held || in_ready) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_hold", 128'(bad), 128'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follows", 128'(in_ready), 128'd1);
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_busy", 128'(busy), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);

        // clear at round 5
        start_block(PT_C, KEY_C);
        waited = 0;
        while (round_idx != 4'd5 && waited < 20) begin tick(); waited++; end
        chk("clr_reach5", 128'(round_idx), 128'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", 128'(out_valid), 128'd0);
        chk("clr_ready", 128'(in_ready), 128'd1);
        chk("clr_busy", 128'(busy), 128'd0);
        chk("clr_round", 128'(round_idx), 128'd0);
        chk("clr_cipher_kept", cipher_out, CT_B);

        // clear beats accept
        data_in = PT_C; key_in = expand(KEY_C); in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_vs_accept", 128'(busy), 128'd0);

        // clear beats final-round completion
        start_block(PT_C, KEY_C);
        waited = 0;
        while (round_idx != 4'd10 && waited < 20) begin tick(); waited++; end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_final_valid", 128'(out_valid), 128'd0);
        chk("clr_final_cipher", cipher_out, CT_B);

        run_block("after_clear", PT_C, KEY_C, CT_C);

        // async reset between clock edges
        start_block(PT_B, KEY_B);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 128'(in_ready), 128'd1);
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_round", 128'(round_idx), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_cipher", cipher_out, 128'd0);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid || busy) bad = 1'b1;
        end
        chk("arst_no_stale", 128'(bad), 128'd0);
        run_block("after_rst", PT_B, KEY_B, CT_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
